// File: rtl/jk_bank_arbiter_if.sv
// Requester-side bundle for the JK bank arbiter: requests, ops and masks in, acks and bank state out.
// The arbiter takes the slave modport; the agent (or bench) drives the master modport.
interface jk_bank_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic                  clr;
   logic [NREQ-1:0]       req;
   logic [2*NREQ-1:0]     jk;
   logic [NREQ*WIDTH-1:0] mask;
   logic [NREQ-1:0]       ack;
   logic                  busy;
   logic [IDW-1:0]        cur_id;
   logic [WIDTH-1:0]      q;
   logic [15:0]           op_cnt;

   modport master (
      output clr, req, jk, mask,
      input  ack, busy, cur_id, q, op_cnt
   );

   modport slave (
      input  clr, req, jk, mask,
      output ack, busy, cur_id, q, op_cnt
   );
endinterface

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter applying one requester's JK op to a masked WIDTH-bit bank.
// Grant -> q/ack 2 edges later, one op per 3 cycles; requesters hold req (level) until ack.
module jk_bank_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   jk_bank_arbiter_if.slave  bus
);
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   cur_id_q, cur_id_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] bank_q, bank_d;
   logic [NREQ-1:0]  ack_q, ack_d;
   logic             busy_q, busy_d;
   logic [15:0]      op_cnt_q, op_cnt_d;
   logic             win_vld;
   logic [IDW-1:0]   win_id;

   // Scan from the farthest offset down so the nearest set bit at/after ptr wins.
   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (bus.req[(int'(ptr_q) + k) % NREQ]) begin
            win_vld = 1'b1;
            win_id  = IDW'((int'(ptr_q) + k) % NREQ);
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cur_id_d = cur_id_q;
      ptr_d    = ptr_q;
      op_d     = op_q;
      mask_d   = mask_q;
      bank_d   = bank_q;
      ack_d    = '0;
      busy_d   = busy_q;
      op_cnt_d = op_cnt_q;

      case (state_q)
         IDLE: begin
            if (win_vld) begin
               cur_id_d = win_id;
               op_d     = bus.jk[2*int'(win_id) +: 2];
               mask_d   = bus.mask[int'(win_id)*WIDTH +: WIDTH];
               busy_d   = 1'b1;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            for (int b = 0; b < WIDTH; b++) begin
               if (mask_q[b]) begin
                  case (op_q)
                     2'b01:   bank_d[b] = 1'b0;
                     2'b10:   bank_d[b] = 1'b1;
                     2'b11:   bank_d[b] = ~bank_q[b];
                     default: bank_d[b] = bank_q[b];
                  endcase
               end
            end
            ack_d[cur_id_q] = 1'b1;
            op_cnt_d        = op_cnt_q + 16'd1;
            ptr_d           = (int'(cur_id_q) == NREQ - 1) ? '0 : cur_id_q + IDW'(1);
            state_d         = ACK;
         end
         ACK: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase

      // Clear drops any latched op unexecuted; counter and pointer survive it.
      if (bus.clr) begin
         bank_d   = '0;
         state_d  = IDLE;
         ack_d    = '0;
         busy_d   = 1'b0;
         op_cnt_d = op_cnt_q;
         ptr_d    = ptr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cur_id_q <= '0;
         ptr_q    <= '0;
         op_q     <= '0;
         mask_q   <= '0;
         bank_q   <= '0;
         ack_q    <= '0;
         busy_q   <= 1'b0;
         op_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         cur_id_q <= cur_id_d;
         ptr_q    <= ptr_d;
         op_q     <= op_d;
         mask_q   <= mask_d;
         bank_q   <= bank_d;
         ack_q    <= ack_d;
         busy_q   <= busy_d;
         op_cnt_q <= op_cnt_d;
      end
   end

   assign bus.ack    = ack_q;
   assign bus.busy   = busy_q;
   assign bus.cur_id = cur_id_q;
   assign bus.q      = bank_q;
   assign bus.op_cnt = op_cnt_q;
endmodule

// File: doc/jk_bank_arbiter.md
# jk_bank_arbiter

Round-robin arbiter and sequencer that shares a WIDTH-bit bank of JK-style storage bits between NREQ requesters. Each requester posts a JK operation (hold/reset/set/toggle) together with a bit mask. The block grants one requester at a time, applies the operation to the masked bits of the bank, and acknowledges it. It sits between the control agents and the JK storage bank, and is the only writer of the bank.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, number of bits in the bank
- clk  in  1  system clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear of the bank and abort of any in-flight operation
- req  in  NREQ  request from requester i at bit i; level, held until ack
- jk  in  2*NREQ  op of requester i at bits [2i+1:2i]; bit 2i+1 = J, bit 2i = K
- mask  in  NREQ*WIDTH  bit mask of requester i at bits [i*WIDTH +: WIDTH]
- ack  out  NREQ  one-cycle acknowledge, one-hot
- busy  out  1  high in states EXEC and ACK
- cur_id  out  clog2(NREQ)  index of the granted requester, valid while busy
- q  out  WIDTH  bank contents
- op_cnt  out  16  count of completed (acked) operations, wraps

## Operation
- Reset (rst_n low, asynchronous): state=IDLE, q=0, ack=0, busy=0, cur_id=0, op_cnt=0, ptr=0.
- FSM states are IDLE, EXEC and ACK. All outputs are registered.
- IDLE: when any req bit is high, pick the winner. The search starts at index ptr and runs upward, wrapping modulo NREQ; the first set bit wins. On the winner:
  - latch the winner index into cur_id;
  - latch the winner's jk into op_r and its mask into mask_r;
  - go to EXEC.
- IDLE with no req bit high: stay in IDLE.
- EXEC: for every bit b with mask_r[b]=1, update q[b] by op_r:
  - 00: hold;
  - 01: q[b]=0;
  - 10: q[b]=1;
  - 11: q[b]=~q[b].
  - Bits with mask_r[b]=0 are unchanged.
  - Also in EXEC: set ack[cur_id]=1, op_cnt=op_cnt+1 (mod 2^16), ptr=(cur_id+1) mod NREQ, and go to ACK.
- ACK: ack is high for exactly this state. req is ignored. Next state is IDLE and ack returns to 0.
- A requester must drop req, or present a new op, by the clock edge that ends the ACK cycle. If req is still high in IDLE, it is treated as a new request.
- clr=1 at an edge:
  - takes priority over everything;
  - sets q=0, state=IDLE, ack=0;
  - leaves op_cnt and ptr unchanged.
  - An operation latched but not yet executed is dropped with no ack. Its requester is still requesting and is re-arbitrated.
  - clr during the ACK state also forces ack low at that edge.
- A mask of all zeros, or op 00, is still a legal operation. It is acked and counted; q is unchanged.
- jk and mask from non-winning requesters have no effect. The winner's jk and mask are sampled only at the grant edge; later changes are ignored.

## Timing
- Edge E0, in IDLE with req high: grant. busy=1 and cur_id are valid after E0.
- Edge E1: q updated, ack[cur_id]=1, op_cnt incremented. All are visible after E1.
- Edge E2: ack=0, busy=0, state=IDLE.
- Earliest next grant is at E3, so one operation completes per 3 cycles at most. Request-to-q latency is 2 edges.
- Fairness: with all NREQ requesters holding req continuously, each is served once per NREQ operations, in index order starting from ptr.
- rst_n assertion mid-operation clears everything immediately. No ack is produced.

## Test plan
Parameters for all scenarios: NREQ=4, WIDTH=8.

- **Set:** reset, then req[2]=1 with jk[5:4]=10 and mask2=8'h0F. Required: cur_id=2 after E0, q=8'h0F and ack=4'b0100 after E1, ack=0 after E2, op_cnt=1.
- **Toggle and reset ops:** with q=8'h0F, req0 with jk=11 and mask=8'hFF gives q=8'hF0. Then req1 with jk=01 and mask=8'h30 gives q=8'hC0. Then req3 with jk=00 and mask=8'hFF gives q unchanged and op_cnt incremented.
- **Round-robin:** hold req=4'b1111 for 12 operations. Required: ack order 0,1,2,3,0,1,2,3,0,1,2,3, one ack every 3 cycles, op_cnt=12.
- **Requester re-request:** req1 is held across the ACK cycle and is the only request. Required: it is granted again at the edge after ACK (two acks, 3 cycles apart).
- **clr mid-op:** req0 with jk=10 and mask=8'hFF, with clr=1 at E1. Required: q=0, no ack, op_cnt unchanged, ptr unchanged. req0 is then regranted and gives q=8'hFF.
- **Async reset and wrap:** rst_n pulsed low mid-EXEC gives immediate q=0, busy=0, ack=0. Separately, preload 65535 operations so that op_cnt=16'hFFFF; one more operation gives op_cnt=0.
